seg_adder_fu: RTL and testbench

SEG_ADDER_FU -- requirements
Module: seg_adder_fu

---
 rtl/seg_adder_fu.sv | 136 +++++++++++++
 tb/tb_seg_adder_fu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_adder_fu.sv
// Segmented SIMD adder/subtractor: lanes fuse into power-of-two groups chosen per beat.
// Two-stage pipeline: S1 registers per-lane carry-select sums, S2 resolves group carries.
module seg_adder_fu #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int MW    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [MW-1:0]          in_mode,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_sum,
  output logic [LANES-1:0]       out_carry,
  output logic [LANES-1:0]       out_ovf,
  output logic                   out_err,
  output logic [31:0]            beat_cnt
);
  localparam int LW = $clog2(LANES);

  logic                   s1_valid_reg;
  logic [LANES*WIDTH-1:0] s1_sum0_reg, s1_sum1_reg;
  logic [LANES-1:0]       s1_c0_reg, s1_c1_reg, s1_amsb_reg, s1_bmsb_reg;
  logic [MW-1:0]          s1_mode_reg;
  logic                   s1_sub_reg;

  logic adv1, adv2, accept;
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && adv1;

  // S1 combinational: both carry-in hypotheses for every lane
  logic [LANES*WIDTH-1:0] sum0_next, sum1_next;
  logic [LANES-1:0]       c0_next, c1_next, amsb_next, bmsb_next;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] a_l, b_l;
      assign a_l = in_a[gi*WIDTH +: WIDTH];
      assign b_l = in_sub ? ~in_b[gi*WIDTH +: WIDTH] : in_b[gi*WIDTH +: WIDTH];
      assign {c0_next[gi], sum0_next[gi*WIDTH +: WIDTH]} = {1'b0, a_l} + {1'b0, b_l};
      assign {c1_next[gi], sum1_next[gi*WIDTH +: WIDTH]} =
        {1'b0, a_l} + {1'b0, b_l} + (WIDTH+1)'(1);
      assign amsb_next[gi] = a_l[WIDTH-1];
      assign bmsb_next[gi] = b_l[WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_sum0_reg  <= '0;
      s1_sum1_reg  <= '0;
      s1_c0_reg    <= '0;
      s1_c1_reg    <= '0;
      s1_amsb_reg  <= '0;
      s1_bmsb_reg  <= '0;
      s1_mode_reg  <= '0;
      s1_sub_reg   <= 1'b0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (accept) begin
        s1_sum0_reg <= sum0_next;
        s1_sum1_reg <= sum1_next;
        s1_c0_reg   <= c0_next;
        s1_c1_reg   <= c1_next;
        s1_amsb_reg <= amsb_next;
        s1_bmsb_reg <= bmsb_next;
        s1_mode_reg <= in_mode;
        s1_sub_reg  <= in_sub;
      end
    end
  end

  // S2 combinational: ripple the lane carries, restarting at each group's lowest lane
  logic                   mode_ok;
  logic [LW-1:0]          grp_mask;
  logic [LANES*WIDTH-1:0] sum_next;
  logic [LANES-1:0]       carry_next, ovf_next;

  assign mode_ok  = (s1_mode_reg <= MW'(LW));
  assign grp_mask = ~({LW{1'b1}} << s1_mode_reg);

  always_comb begin
    logic cin, cout, msb;
    sum_next   = '0;
    carry_next = '0;
    ovf_next   = '0;
    cin        = s1_sub_reg;
    for (int k = 0; k < LANES; k++) begin
      if ((LW'(k) & grp_mask) == '0) cin = s1_sub_reg;
      cout = cin ? s1_c1_reg[k] : s1_c0_reg[k];
      sum_next[k*WIDTH +: WIDTH] = cin ? s1_sum1_reg[k*WIDTH +: WIDTH]
                                       : s1_sum0_reg[k*WIDTH +: WIDTH];
      msb = sum_next[k*WIDTH + WIDTH - 1];
      if ((LW'(k) & grp_mask) == grp_mask) begin
        carry_next[k] = cout;
        ovf_next[k]   = cout ^ (msb ^ s1_amsb_reg[k] ^ s1_bmsb_reg[k]);
      end
      cin = cout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= '0;
      out_ovf   <= '0;
      out_err   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_sum   <= mode_ok ? sum_next : '0;
        out_carry <= mode_ok ? carry_next : '0;
        out_ovf   <= mode_ok ? ovf_next : '0;
        out_err   <= !mode_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_seg_adder_fu.sv
// Directed-vector bench for seg_adder_fu at WIDTH=16, LANES=4, MW=2.
module tb_seg_adder_fu;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a, in_b;
  logic [1:0]  in_mode;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic [3:0]  out_carry, out_ovf;
  logic        out_err;
  logic [31:0] beat_cnt;

  int checks = 0;
  int failures = 0;
  int exp_beats = 0;

  seg_adder_fu #(.WIDTH(16), .LANES(4), .MW(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_err(out_err), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Offer one beat, then wait (bounded) for its result; lat counts edges from the accept edge.
  task automatic run_single(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m,
                            input logic s, output logic [72:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_sub = s; out_ready = 1'b1;
    for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = {out_sum, out_carry, out_ovf, out_err};
    if (out_valid) exp_beats++;
    $display("beat mode=%0d sub=%0d a=%h b=%h -> sum=%h carry=%b ovf=%b err=%b lat=%0d",
             m, s, a, b, out_sum, out_carry, out_ovf, out_err, lat);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_sub = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
    checks++;
    if ({out_valid, out_err, out_sum, out_carry, out_ovf, beat_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b err=%b sum=%h carry=%b ovf=%b cnt=%0d expected all 0",
               out_valid, out_err, out_sum, out_carry, out_ovf, beat_cnt);
    end
    reset_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_mode0_add;
    logic [72:0] r; int lat;
    run_single(64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_0001_0001_0001, 2'd0, 1'b0, r, lat);
    checks++;
    if (r !== {64'h0, 4'b1111, 4'b0000, 1'b0}) begin
      failures++; $display("FAIL mode0_add got %h expected %h", r, {64'h0, 4'b1111, 4'b0000, 1'b0});
    end
    checks++;
    if (lat !== 2) begin
      failures++; $display("FAIL mode0_add_latency got %0d expected 2", lat);
    end
  endtask

  task automatic test_mode2_add;
    logic [72:0] r; int lat;
    run_single(64'h0000_0000_0000_FFFF, 64'h1, 2'd2, 1'b0, r, lat);
    checks++;
    if (r !== {64'h0000_0000_0001_0000, 4'b0000, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL mode2_add got %h expected %h", r, {64'h0000_0000_0001_0000, 4'b0000, 4'b0000, 1'b0});
    end
    checks++;
    if (lat !== 2) begin
      failures++; $display("FAIL mode2_add_latency got %0d expected 2", lat);
    end
  endtask

  task automatic test_mode1_sub;
    logic [72:0] r; int lat;
    run_single(64'h0001_0000_0001_0000, 64'h0000_0001_0000_0001, 2'd1, 1'b1, r, lat);
    checks++;
    if (r !== {64'h0000_FFFF_0000_FFFF, 4'b1010, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL mode1_sub got %h expected %h", r, {64'h0000_FFFF_0000_FFFF, 4'b1010, 4'b0000, 1'b0});
    end
    // Group 0: 0x7FFFFFFF - (-1) overflows and borrows; group 1: 0 - 0 no borrow.
    run_single(64'h0000_0000_7FFF_FFFF, 64'h0000_0000_FFFF_FFFF, 2'd1, 1'b1, r, lat);
    checks++;
    if (r !== {64'h0000_0000_8000_0000, 4'b1000, 4'b0010, 1'b0}) begin
      failures++;
      $display("FAIL mode1_sub_ovf got %h expected %h", r, {64'h0000_0000_8000_0000, 4'b1000, 4'b0010, 1'b0});
    end
  endtask

  task automatic test_mode1_add_boundary;
    logic [72:0] r; int lat;
    // Group 0 carries out but must not leak into group 1, which overflows on its own.
    run_single(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0001, 2'd1, 1'b0, r, lat);
    checks++;
    if (r !== {64'h8000_0000_0000_0000, 4'b0010, 4'b1000, 1'b0}) begin
      failures++;
      $display("FAIL mode1_add_boundary got %h expected %h", r, {64'h8000_0000_0000_0000, 4'b0010, 4'b1000, 1'b0});
    end
  endtask

  task automatic test_mode0_sub;
    logic [72:0] r; int lat;
    run_single(64'h0005_0000_8000_0003, 64'h0003_0001_0001_0003, 2'd0, 1'b1, r, lat);
    checks++;
    if (r !== {64'h0002_FFFF_7FFF_0000, 4'b1011, 4'b0010, 1'b0}) begin
      failures++;
      $display("FAIL mode0_sub got %h expected %h", r, {64'h0002_FFFF_7FFF_0000, 4'b1011, 4'b0010, 1'b0});
    end
  endtask

  task automatic test_illegal_mode;
    logic [72:0] r; int lat;
    run_single(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 2'd3, 1'b0, r, lat);
    checks++;
    if (r !== {64'h0, 4'b0000, 4'b0000, 1'b1}) begin
      failures++; $display("FAIL illegal_mode got %h expected %h", r, {64'h0, 4'b0000, 4'b0000, 1'b1});
    end
    checks++;
    if (lat !== 2) begin
      failures++; $display("FAIL illegal_mode_latency got %0d expected 2", lat);
    end
    run_single(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 2'd0, 1'b0, r, lat);
    checks++;
    if (r !== {64'h0011_0022_0033_0044, 4'b0000, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL after_illegal got %h expected %h", r, {64'h0011_0022_0033_0044, 4'b0000, 4'b0000, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] va [3];
    logic [63:0] ve [3];
    logic [63:0] got [3];
    int idx, nres;
    logic acc;
    for (int k = 0; k < 3; k++) begin
      va[k] = 64'h0001_0001_0001_0001 * (k + 1);
      ve[k] = 64'h0010_0010_0010_0010 + va[k];
      got[k] = '0;
    end
    idx = 0;
    nres = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_b = 64'h0010_0010_0010_0010; in_mode = 2'd0; in_sub = 1'b0;
      if (idx < 3) begin in_valid = 1'b1; in_a = va[idx]; end else in_valid = 1'b0;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    checks++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_stall_accepts got %0d ready=%b expected 2 ready=0", idx, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== ve[0]) begin
      failures++; $display("FAIL b2b_stall_hold got valid=%b sum=%h expected 1 %h", out_valid, out_sum, ve[0]);
    end
    for (int c = 0; c < 12 && nres < 3; c++) begin
      if (c > 0) @(negedge clk);
      out_ready = 1'b1;
      if (idx < 3) begin in_valid = 1'b1; in_a = va[idx]; end else in_valid = 1'b0;
      acc = in_valid && in_ready;
      if (out_valid) begin
        got[nres] = out_sum;
        $display("b2b result %0d sum=%h", nres, out_sum);
        nres++;
        exp_beats++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (nres !== 3) begin
      failures++; $display("FAIL b2b_result_count got %0d expected 3", nres);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k] !== ve[k]) begin
        failures++; $display("FAIL b2b_order_%0d got %h expected %h", k, got[k], ve[k]);
      end
    end
    checks++;
    if (beat_cnt !== 32'(exp_beats)) begin
      failures++; $display("FAIL b2b_beat_cnt got %0d expected %0d", beat_cnt, exp_beats);
    end
  endtask

  task automatic test_reset_in_flight;
    logic [72:0] r; int lat, stale;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_a = 64'hAAAA_0000_5555_0001 + 64'(c);
      in_b = 64'h1; in_mode = 2'd2; in_sub = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 32'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_flight got valid=%b cnt=%0d ready=%b expected 0 0 1", out_valid, beat_cnt, in_ready);
    end
    exp_beats = 0;
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      failures++; $display("FAIL reset_stale_results got %0d expected 0", stale);
    end
    run_single(64'h0000_0000_0000_0002, 64'h0000_0000_0000_0003, 2'd0, 1'b0, r, lat);
    checks++;
    if (r !== {64'h5, 4'b0000, 4'b0000, 1'b0}) begin
      failures++; $display("FAIL post_reset_beat got %h expected %h", r, {64'h5, 4'b0000, 4'b0000, 1'b0});
    end
    @(negedge clk);
    checks++;
    if (beat_cnt !== 32'(exp_beats)) begin
      failures++; $display("FAIL post_reset_beat_cnt got %0d expected %0d", beat_cnt, exp_beats);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_add();
    test_mode2_add();
    test_mode1_sub();
    test_mode1_add_boundary();
    test_mode0_sub();
    test_illegal_mode();
    test_back_to_back();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
